// File: rtl/psg_pkg.sv
// Shared constants and the PSG-to-PCM conversion used by the I2S output stage.
package psg_pkg;

    localparam int PCM_W     = 16;
    localparam int PSG_W     = 10;
    localparam int PSG_MID   = 512;
    localparam int I2S_SLOTS = 32;

    typedef logic [PCM_W-1:0] pcm_t;

    // Re-centre the unsigned PSG word on zero and scale it to full-range signed PCM.
    function automatic pcm_t psg_to_pcm(input logic [PSG_W-1:0] s);
        logic [PSG_W:0] d;
        d = {1'b0, s} - 11'(PSG_MID);
        return {d[PSG_W-1:0], 6'b000000};
    endfunction

endpackage

// File: rtl/psg_sfifo.sv
// Small synchronous FIFO; the pop request is ignored while empty and a push
// is accepted when full only if a pop frees a slot in the same cycle.
module psg_sfifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents need no reset because the level guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end else begin
                r_level <= r_level;
            end
        end
    end

endmodule

// File: rtl/psg_i2s_tx.sv
// PSG output stage: converts each sound word to PCM, buffers it and serialises
// it as mono-duplicated I2S with locally generated BCLK/LRCK.
module psg_i2s_tx
    import psg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_DIV   = 8,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PSG_W-1:0] sound,
    input  logic             sample,
    output logic             i2s_bclk,
    output logic             i2s_lrck,
    output logic             i2s_sdata,
    output logic [LW-1:0]    fifo_level,
    output logic             overflow,
    output logic             underrun
);

    localparam int DIV_W  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int SLOT_W = $clog2(I2S_SLOTS);

    pcm_t              r_pcm;
    logic              r_push;
    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_bclk;
    logic [SLOT_W-1:0] r_slot;
    pcm_t              r_held;
    logic              r_lrck;
    logic              r_sdata;
    logic              r_overflow;
    logic              r_underrun;

    pcm_t              w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_tc;
    logic              w_fall;
    logic [SLOT_W-1:0] w_next_slot;
    logic              w_frame_start;
    pcm_t              w_word;
    logic [3:0]        w_bit_idx;

    psg_sfifo #(
        .WIDTH (PCM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_push),
        .i_din   (r_pcm),
        .i_pop   (w_frame_start),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_tc          = (r_div_cnt == DIV_W'(BCLK_DIV - 1));
    assign w_fall        = w_tc && r_bclk;
    assign w_next_slot   = r_slot + 5'd1;
    assign w_frame_start = w_fall && (w_next_slot == 5'd0);
    assign w_bit_idx     = 4'd15 - w_next_slot[3:0];

    // Word to transmit in the slot being entered: a fresh FIFO head at frame start, else the held word.
    always_comb begin
        w_word = r_held;
        if (w_frame_start && !w_empty) begin
            w_word = w_head;
        end else begin
            w_word = r_held;
        end
    end

    // Conversion register, bit-clock divider, slot/serial logic and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcm      <= 16'h0000;
            r_push     <= 1'b0;
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_slot     <= 5'd31;
            r_held     <= 16'h0000;
            r_lrck     <= 1'b0;
            r_sdata    <= 1'b0;
            r_overflow <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_push <= sample;
            if (sample) begin
                r_pcm <= psg_to_pcm(sound);
            end
            if (w_tc) begin
                r_div_cnt <= '0;
                r_bclk    <= !r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_fall) begin
                r_slot  <= w_next_slot;
                r_held  <= w_word;
                r_sdata <= w_word[w_bit_idx];
                // LRCK leads the MSB of each channel by one BCLK.
                r_lrck  <= (w_next_slot >= 5'd15) && (w_next_slot <= 5'd30);
            end
            if (w_frame_start && w_empty) begin
                r_underrun <= 1'b1;
            end
            if (r_push && w_full && !w_frame_start) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign i2s_bclk  = r_bclk;
    assign i2s_lrck  = r_lrck;
    assign i2s_sdata = r_sdata;
    assign overflow  = r_overflow;
    assign underrun  = r_underrun;

endmodule
